oam_dma: RTL and testbench

- CPU-side sprite DMA engine for register $4014. It is the writer feeding the PPU sprite unit's OAM data port.
- A CPU write of page P to $4014 halts the CPU. The engine then copies 256 bytes from CPU addresses P00..PFF into $2004 (OAMDATA), one read/write pair per byte.
- It sits between the CPU core and the CPU bus mux in the top level.
- Its write strobe is ORed into the PPU's wr2004, and its data is muxed onto regwdata.

---
 rtl/oam_dma_pkg.sv | 23 ++
 rtl/oam_dma.sv | 132 +++++++++++++
 tb/tb_oam_dma.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_pkg.sv
// Shared constants and output bundle for the $4014 sprite DMA engine.
package oam_dma_pkg;

    localparam int unsigned NBYTES = 256;
    localparam int unsigned CNT_W  = $clog2(NBYTES);
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned PAGE_W = ADDR_W - CNT_W;

    localparam logic [ADDR_W-1:0] OAMDATA_ADDR = 16'h2004;

    // Registered bus-side view of the engine.
    typedef struct packed {
        logic              halt;
        logic              dmaact;
        logic              dmard;
        logic              dmawr;
        logic              busy;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dma_out_t;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: halts the CPU and copies page P00..PFF into OAMDATA, one
// read/write pair per byte, aligned so reads land on get (cyc=0) cycles.
module oam_dma
    import oam_dma_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              wr4014,
    input  logic [DATA_W-1:0] regwdata,
    input  logic              cpurw,
    input  logic [DATA_W-1:0] cpurdata,
    output logic              halt,
    output logic              dmaact,
    output logic [ADDR_W-1:0] dmaaddr,
    output logic              dmard,
    output logic              dmawr,
    output logic [DATA_W-1:0] dmawdata,
    output logic              busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HALT  = 3'd1;
    localparam logic [2:0] S_ALIGN = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              cyc_q;
    logic [PAGE_W-1:0] page_q, page_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] data_q, data_d;
    dma_out_t          out_q, out_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else if (tick) begin
            state_q <= state_d;
        end
    end

    // Next state plus page/count/data updates.
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        count_d = count_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (wr4014) begin
                    page_d  = PAGE_W'(regwdata);
                    count_d = '0;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                // The following cycle is a get cycle exactly when cyc is 1 now.
                if (cpurw) begin
                    state_d = cyc_q ? S_READ : S_ALIGN;
                end
            end
            S_ALIGN: state_d = S_READ;
            S_READ: begin
                data_d  = cpurdata;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                count_d = count_q + CNT_W'(1);
                state_d = (count_q == CNT_W'(NBYTES - 1)) ? S_IDLE : S_READ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the state being entered, so they register with it.
    always_comb begin
        out_d = '0;
        case (state_d)
            S_HALT: begin
                out_d.halt = 1'b1;
                out_d.busy = 1'b1;
            end
            S_ALIGN: begin
                out_d.halt   = 1'b1;
                out_d.busy   = 1'b1;
                out_d.dmaact = 1'b1;
            end
            S_READ: begin
                out_d.halt   = 1'b1;
                out_d.busy   = 1'b1;
                out_d.dmaact = 1'b1;
                out_d.dmard  = 1'b1;
                out_d.addr   = {page_d, count_d};
            end
            S_WRITE: begin
                out_d.halt   = 1'b1;
                out_d.busy   = 1'b1;
                out_d.dmaact = 1'b1;
                out_d.dmawr  = 1'b1;
                out_d.addr   = OAMDATA_ADDR;
                out_d.wdata  = data_d;
            end
            default: out_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q   <= 1'b0;
            page_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
            out_q   <= '0;
        end else if (tick) begin
            cyc_q   <= ~cyc_q;
            page_q  <= page_d;
            count_q <= count_d;
            data_q  <= data_d;
            out_q   <= out_d;
        end
    end

    assign halt     = out_q.halt;
    assign dmaact   = out_q.dmaact;
    assign dmard    = out_q.dmard;
    assign dmawr    = out_q.dmawr;
    assign busy     = out_q.busy;
    assign dmaaddr  = out_q.addr;
    assign dmawdata = out_q.wdata;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: full transfers, alignment, write deferral,
// page FF, tick freeze, ignored re-trigger and mid-transfer reset.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset, tick, wr4014, cpurw;
    logic [7:0]  regwdata, cpurdata;
    logic        halt, dmaact, dmard, dmawr, busy;
    logic [15:0] dmaaddr;
    logic [7:0]  dmawdata;

    always #5 clk = ~clk;

    oam_dma dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .wr4014   (wr4014),
        .regwdata (regwdata),
        .cpurw    (cpurw),
        .cpurdata (cpurdata),
        .halt     (halt),
        .dmaact   (dmaact),
        .dmaaddr  (dmaaddr),
        .dmard    (dmard),
        .dmawr    (dmawr),
        .dmawdata (dmawdata),
        .busy     (busy)
    );

    // CPU memory image: page 02 holds k^5A.
    function automatic logic [7:0] mem_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h58;
    endfunction

    assign cpurdata = mem_val(dmaaddr);

    wire [28:0] snap = {halt, dmaact, dmard, dmawr, busy, dmaaddr, dmawdata};

    int          n_assert = 0;
    int          n_fail   = 0;
    logic        bcyc;
    int          n_halt, n_align, n_rd, n_wr, seq_err, odd_err, freeze_err, steps;
    logic [15:0] first_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (tick && reset) bcyc = ~bcyc;
        @(negedge clk);
    endtask

    task automatic align_to(input logic c);
        while (bcyc !== c) cycle();
    endtask

    // Issue wr4014 and follow the transfer until halt drops.
    task automatic xfer(input logic [7:0] pg, input int defer, input int poke_at,
                        input int freeze_at);
        logic [7:0]  k_rd, k_wr;
        logic [28:0] hold;
        int          n_hs;
        k_rd = 8'h00; k_wr = 8'h00; n_hs = 0;
        n_halt = 0; n_align = 0; n_rd = 0; n_wr = 0;
        seq_err = 0; odd_err = 0; freeze_err = 0; first_addr = 16'hDEAD;
        wr4014 = 1'b1; regwdata = pg; cpurw = 1'b0;
        cycle();
        wr4014 = 1'b0; regwdata = 8'h00;
        steps = 0;
        while (halt && steps < 2000) begin
            n_halt++;
            if (!dmaact) begin
                n_hs++;
                cpurw = (n_hs > defer);
                if (dmard || dmawr || n_rd != 0) seq_err++;
            end else begin
                cpurw = 1'b1;
                if (dmard) begin
                    if (n_rd == 0) first_addr = dmaaddr;
                    if (dmaaddr !== {pg, k_rd} || dmawr) seq_err++;
                    if (bcyc) odd_err++;
                    k_rd++; n_rd++;
                end else if (dmawr) begin
                    if (dmaaddr !== 16'h2004 || dmawdata !== mem_val({pg, k_wr})) seq_err++;
                    k_wr++; n_wr++;
                end else begin
                    n_align++;
                end
            end
            wr4014   = (steps == poke_at);
            regwdata = (steps == poke_at) ? ~pg : 8'h00;
            if (steps == freeze_at) begin
                hold = snap;
                tick = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    cycle();
                    if (snap !== hold) freeze_err++;
                end
                tick = 1'b1;
            end
            cycle();
            steps++;
        end
        wr4014 = 1'b0; regwdata = 8'h00; cpurw = 1'b1;
    endtask

    task automatic post(input string tag, input int exp_halt, input int exp_align,
                        input logic [15:0] exp_first);
        chk({tag, "_done"},   32'(steps < 2000), 32'd1);
        chk({tag, "_halt"},   32'(n_halt), 32'(exp_halt));
        chk({tag, "_align"},  32'(n_align), 32'(exp_align));
        chk({tag, "_nrd"},    32'(n_rd), 32'd256);
        chk({tag, "_nwr"},    32'(n_wr), 32'd256);
        chk({tag, "_seq"},    32'(seq_err), 32'd0);
        chk({tag, "_getcyc"}, 32'(odd_err), 32'd0);
        chk({tag, "_first"},  32'(first_addr), 32'(exp_first));
        chk({tag, "_busy"},   32'(busy), 32'd0);
        chk({tag, "_dmaact"}, 32'(dmaact), 32'd0);
    endtask

    initial begin
        reset = 1'b0; tick = 1'b1; wr4014 = 1'b0; cpurw = 1'b1; regwdata = 8'h00;
        bcyc = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_outs", 32'(snap), 32'd0);
        reset = 1'b1;

        // wr4014 on a cyc=0 cycle: HALT sits on cyc=1, so no alignment.
        align_to(1'b0);
        xfer(8'h02, 0, -1, -1);
        post("basic", 513, 0, 16'h0200);

        // wr4014 on a cyc=1 cycle: one ALIGN cycle before the first read.
        align_to(1'b1);
        xfer(8'h02, 0, -1, -1);
        post("align", 514, 1, 16'h0200);

        // CPU finishes two more writes while halted.
        align_to(1'b0);
        xfer(8'h02, 2, -1, -1);
        post("defer", 515, 0, 16'h0200);

        align_to(1'b0);
        xfer(8'hFF, 0, -1, -1);
        post("pageff", 513, 0, 16'hFF00);

        // Re-trigger while busy is ignored; tick frozen for 10 clocks mid-run.
        align_to(1'b0);
        xfer(8'h02, 0, 50, 101);
        post("busyfrz", 513, 0, 16'h0200);
        chk("freeze_stable", 32'(freeze_err), 32'd0);

        // Reset in the 100th WRITE cycle.
        align_to(1'b0);
        wr4014 = 1'b1; regwdata = 8'h02; cpurw = 1'b0;
        cycle();
        wr4014 = 1'b0; regwdata = 8'h00; cpurw = 1'b1;
        n_wr = 0; steps = 0;
        while (n_wr < 100 && steps < 2000) begin
            if (dmawr) n_wr++;
            if (n_wr < 100) begin
                cycle();
                steps++;
            end
        end
        chk("mrst_reach", 32'(dmawr), 32'd1);
        reset = 1'b0;
        #1;
        chk("mrst_halt",   32'(halt), 32'd0);
        chk("mrst_dmaact", 32'(dmaact), 32'd0);
        chk("mrst_dmawr",  32'(dmawr), 32'd0);
        chk("mrst_busy",   32'(busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("mrst_hold_wr", 32'(dmawr), 32'd0);
        bcyc  = 1'b0;
        reset = 1'b1;
        xfer(8'h03, 0, -1, -1);
        post("restart", 513, 0, 16'h0300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
